// File: rtl/vnu_sched_if.sv
// Scheduler bus for the shared shuffled VNU.
// Groups the control handshake, the LLR/C2V read port, the VNU operand and
// result buses and the V2C/APP write-back port.
//   slave  : the scheduler side (vnu_sched)
//   master : the environment side (memories, VNU, controller)
// Parameters: ADDR_W node-address width, ITER_W iteration-counter width.
interface vnu_sched_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned ITER_W = 4
);
    // control
    logic                    i_start;
    logic                    i_hold;
    logic                    o_busy;
    logic                    o_done;
    logic [ITER_W-1:0]       o_iter;
    // LLR / C2V memory read port
    logic [ADDR_W-1:0]       o_rd_addr;
    logic                    o_rd_en;
    logic [8:0]              i_llr;
    logic [3:0][5:0]         i_c2v;
    // VNU operands and result
    logic [8:0]              o_vnu_lo;
    logic [3:0][5:0]         o_vnu_data;
    logic [4:0][9:0]         i_vnu_data;
    // V2C / APP memory write port
    logic                    o_wr_en;
    logic [ADDR_W-1:0]       o_wr_addr;
    logic [3:0][9:0]         o_v2c;
    logic [9:0]              o_app;
    logic                    o_hd;

    modport slave (
        input  i_start, i_hold, i_llr, i_c2v, i_vnu_data,
        output o_busy, o_done, o_iter, o_rd_addr, o_rd_en,
               o_vnu_lo, o_vnu_data, o_wr_en, o_wr_addr, o_v2c, o_app, o_hd
    );

    modport master (
        output i_start, i_hold, i_llr, i_c2v, i_vnu_data,
        input  o_busy, o_done, o_iter, o_rd_addr, o_rd_en,
               o_vnu_lo, o_vnu_data, o_wr_en, o_wr_addr, o_v2c, o_app, o_hd
    );
endinterface

// File: rtl/vnu_sched.sv
// Scheduler for one shared, purely combinational shuffled VNU.
// Walks all N_VN variable nodes for N_ITER iterations, one node per unheld
// cycle, through a three-stage pipeline:
//   S0 : read strobe and node address to the LLR/C2V memories
//   S1 : read data captured into the VNU operand registers
//   S2 : VNU result captured into the V2C/APP registers, write strobe high
// Read data for the address issued in S0 is sampled at the edge closing S0,
// so the write strobe for a node comes two cycles after its read strobe.
// i_hold freezes the FSM, counters and every pipeline register and masks the
// read/write strobes and the done pulse.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  vnu_sched_if.slave (control, read port, VNU buses, write port)
module vnu_sched #(
    parameter int unsigned N_VN   = 64,
    parameter int unsigned N_ITER = 8,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned ITER_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    vnu_sched_if.slave  bus
);

    localparam int unsigned LLR_W = 9;
    localparam int unsigned C2V_W = 6;
    localparam int unsigned V2C_W = 10;
    localparam int unsigned N_EDG = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                        state;
    state_t                        state_nxt;

    logic [ADDR_W-1:0]             vn;
    logic [ITER_W-1:0]             iter;
    logic                          s1_vld;
    logic                          s2_vld;
    logic [ADDR_W-1:0]             s1_addr;
    logic [ADDR_W-1:0]             s2_addr;
    logic [LLR_W-1:0]              lo_q;
    logic [N_EDG-1:0][C2V_W-1:0]   c2v_q;
    logic [N_EDG-1:0][V2C_W-1:0]   v2c_q;
    logic [V2C_W-1:0]              app_q;

    logic                          adv;
    logic                          last_vn;
    logic                          last_iter;
    logic                          rd_en;
    logic                          wr_en;
    logic                          done;
    logic                          busy;

    // Pipeline advances on every unheld cycle
    assign adv       = ~bus.i_hold;
    assign last_vn   = (vn == ADDR_W'(N_VN - 1));
    assign last_iter = (iter == ITER_W'(N_ITER - 1));

    // State register
    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and strobe decode
    always_comb begin : state_dec
        state_nxt = state;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        done      = 1'b0;
        busy      = 1'b0;

        wr_en = s2_vld & adv;

        case (state)
            IDLE: begin
                if (adv && bus.i_start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                rd_en = adv;
                if (adv && last_vn && last_iter) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                // S1 empty means the node in S2 is the last one and leaves at this edge
                if (adv && !s1_vld) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = adv;
                if (adv) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Node/iteration counters
    always_ff @(posedge clk) begin : cnt_regs
        if (rst) begin
            vn   <= '0;
            iter <= '0;
        end else if (adv) begin
            if (state == RUN) begin
                if (last_vn) begin
                    vn <= '0;
                    // Iteration index stays on the final value while draining
                    if (!last_iter) begin
                        iter <= iter + ITER_W'(1);
                    end
                end else begin
                    vn <= vn + ADDR_W'(1);
                end
            end else if (state == DONE) begin
                vn   <= '0;
                iter <= '0;
            end
        end
    end

    // S1: memory read data into VNU operand registers (raw bits)
    always_ff @(posedge clk) begin : s1_regs
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_addr <= '0;
            lo_q    <= '0;
            c2v_q   <= '0;
        end else if (adv) begin
            s1_vld <= (state == RUN);
            if (state == RUN) begin
                s1_addr <= vn;
                lo_q    <= bus.i_llr;
                c2v_q   <= bus.i_c2v;
            end
        end
    end

    // S2: VNU result into write-back registers (raw bits)
    always_ff @(posedge clk) begin : s2_regs
        if (rst) begin
            s2_vld  <= 1'b0;
            s2_addr <= '0;
            v2c_q   <= '0;
            app_q   <= '0;
        end else if (adv) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_addr <= s1_addr;
                v2c_q   <= bus.i_vnu_data[N_EDG-1:0];
                app_q   <= bus.i_vnu_data[N_EDG];
            end
        end
    end

    assign bus.o_busy     = busy;
    assign bus.o_done     = done;
    assign bus.o_iter     = iter;
    assign bus.o_rd_addr  = vn;
    assign bus.o_rd_en    = rd_en;
    assign bus.o_vnu_lo   = lo_q;
    assign bus.o_vnu_data = c2v_q;
    assign bus.o_wr_en    = wr_en;
    assign bus.o_wr_addr  = s2_addr;
    assign bus.o_v2c      = v2c_q;
    assign bus.o_app      = app_q;
    // Hard decision is the APP sign, aligned with the write strobe
    assign bus.o_hd       = app_q[V2C_W-1];

endmodule

// File: tb/tb_vnu_sched.sv
// Directed bench for vnu_sched: two instances (N_VN=4 with N_ITER=1 and 3),
// a behavioural LLR/C2V memory and a behavioural sign-magnitude VNU.
module tb_vnu_sched;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    vnu_sched_if #(.ADDR_W(2), .ITER_W(1)) ifa ();
    vnu_sched_if #(.ADDR_W(2), .ITER_W(2)) ifb ();

    vnu_sched #(.N_VN(4), .N_ITER(1), .ADDR_W(2), .ITER_W(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    vnu_sched #(.N_VN(4), .N_ITER(3), .ADDR_W(2), .ITER_W(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    // node tables and hand-computed VNU results
    logic [8:0]       llr_mem [4];
    logic [3:0][5:0]  c2v_mem [4];
    logic [9:0]       app_tab [4];
    logic [3:0][9:0]  v2c_tab [4];

    function automatic int sm6(input logic [5:0] v);
        int m;
        m = int'({27'd0, v[4:0]});
        return v[5] ? -m : m;
    endfunction

    function automatic logic [9:0] sm10(input int v);
        int m;
        m = (v < 0) ? -v : v;
        if (m > 511) m = 511;
        return {(v < 0), 9'(m)};
    endfunction

    function automatic logic [4:0][9:0] vnu_model(input logic [8:0] lo, input logic [3:0][5:0] c);
        int tot;
        logic [4:0][9:0] r;
        tot = int'($signed(lo));
        for (int i = 0; i < 4; i++) tot = tot + sm6(c[i]);
        r[4] = sm10(tot);
        for (int i = 0; i < 4; i++) r[i] = sm10(tot - sm6(c[i]));
        return r;
    endfunction

    assign ifa.i_llr      = llr_mem[ifa.o_rd_addr];
    assign ifa.i_c2v      = c2v_mem[ifa.o_rd_addr];
    assign ifa.i_vnu_data = vnu_model(ifa.o_vnu_lo, ifa.o_vnu_data);
    assign ifb.i_llr      = llr_mem[ifb.o_rd_addr];
    assign ifb.i_c2v      = c2v_mem[ifb.o_rd_addr];
    assign ifb.i_vnu_data = vnu_model(ifb.o_vnu_lo, ifb.o_vnu_data);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full N_ITER=1 run on dut_a with an optional hold window and start glitches
    task automatic run_a(input int hold_at, input int hold_len, input bit glitch);
        int  vc;
        int  wi;
        bit  held;
        ifa.i_start = 1'b1;
        tick();
        ifa.i_start = 1'b0;
        for (int s = 0; s < 8 + hold_len; s++) begin
            held = (s >= hold_at) && (s < hold_at + hold_len);
            vc   = (s < hold_at) ? s : s - hold_len;
            ifa.i_hold  = held;
            ifa.i_start = glitch && !held && (vc == 1 || vc == 6);
            #1;
            if (held) begin
                chk("hold_rd_en", 64'(ifa.o_rd_en), 64'(0));
                chk("hold_wr_en", 64'(ifa.o_wr_en), 64'(0));
                chk("hold_busy",  64'(ifa.o_busy),  64'(1));
            end else begin
                chk("rd_en", 64'(ifa.o_rd_en), 64'(vc < 4));
                if (vc < 4) begin
                    chk("rd_addr", 64'(ifa.o_rd_addr), 64'(vc));
                    chk("iter",    64'(ifa.o_iter),    64'(0));
                end
                if (vc >= 1 && vc <= 4) begin
                    chk("vnu_lo",   64'(ifa.o_vnu_lo),   64'(llr_mem[vc-1]));
                    chk("vnu_data", 64'(ifa.o_vnu_data), 64'(c2v_mem[vc-1]));
                end
                chk("wr_en", 64'(ifa.o_wr_en), 64'(vc >= 2 && vc < 6));
                if (vc >= 2 && vc < 6) begin
                    wi = vc - 2;
                    chk("wr_addr", 64'(ifa.o_wr_addr), 64'(wi));
                    chk("app",     64'(ifa.o_app),     64'(app_tab[wi]));
                    chk("hd",      64'(ifa.o_hd),      64'(app_tab[wi][9]));
                    chk("v2c",     64'(ifa.o_v2c),     64'(v2c_tab[wi]));
                end
                chk("done", 64'(ifa.o_done), 64'(vc == 6));
                chk("busy", 64'(ifa.o_busy), 64'(vc < 6));
            end
            tick();
        end
        ifa.i_hold  = 1'b0;
        ifa.i_start = 1'b0;
        #1;
        chk("idle_busy",  64'(ifa.o_busy),  64'(0));
        chk("idle_rd_en", 64'(ifa.o_rd_en), 64'(0));
        chk("idle_done",  64'(ifa.o_done),  64'(0));
        tick();
    endtask

    initial begin
        int writes;
        int dones;

        llr_mem[0] = 9'd20;  c2v_mem[0] = '0;
        llr_mem[1] = 9'h1EC; c2v_mem[1] = '0;
        llr_mem[2] = 9'd5;   c2v_mem[2] = {6'd1, 6'd0, 6'h22, 6'd3};
        llr_mem[3] = 9'h19C; c2v_mem[3] = {6'd10, 6'd10, 6'd10, 6'd10};
        // node0 +20, node1 -20, node2 5+3-2+0+1=7, node3 -100+40=-60
        app_tab[0] = 10'd20;  v2c_tab[0] = {10'd20, 10'd20, 10'd20, 10'd20};
        app_tab[1] = 10'h214; v2c_tab[1] = {10'h214, 10'h214, 10'h214, 10'h214};
        app_tab[2] = 10'd7;   v2c_tab[2] = {10'd6, 10'd7, 10'd9, 10'd4};
        app_tab[3] = 10'h23C; v2c_tab[3] = {10'h246, 10'h246, 10'h246, 10'h246};

        rst = 1'b1;
        ifa.i_start = 1'b0; ifa.i_hold = 1'b0;
        ifb.i_start = 1'b0; ifb.i_hold = 1'b0;
        repeat (3) tick();

        // reset state
        chk("rst_busy",    64'(ifa.o_busy),     64'(0));
        chk("rst_done",    64'(ifa.o_done),     64'(0));
        chk("rst_rd_en",   64'(ifa.o_rd_en),    64'(0));
        chk("rst_wr_en",   64'(ifa.o_wr_en),    64'(0));
        chk("rst_iter",    64'(ifa.o_iter),     64'(0));
        chk("rst_rd_addr", 64'(ifa.o_rd_addr),  64'(0));
        chk("rst_wr_addr", 64'(ifa.o_wr_addr),  64'(0));
        chk("rst_lo",      64'(ifa.o_vnu_lo),   64'(0));
        chk("rst_app",     64'(ifa.o_app),      64'(0));
        chk("rst_v2c",     64'(ifa.o_v2c),      64'(0));
        chk("rst_hd",      64'(ifa.o_hd),       64'(0));
        rst = 1'b0;
        tick();

        // plain run, then the same run with a 3-cycle hold while S0/S1/S2 are all full
        run_a(100, 0, 1'b0);
        run_a(2, 3, 1'b0);

        // reset while the write address is 1
        ifa.i_start = 1'b1;
        tick();
        ifa.i_start = 1'b0;
        repeat (3) tick();
        chk("pre_rst_wr_en",   64'(ifa.o_wr_en),   64'(1));
        chk("pre_rst_wr_addr", 64'(ifa.o_wr_addr), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_wr_en", 64'(ifa.o_wr_en), 64'(0));
        chk("mid_rst_busy",  64'(ifa.o_busy),  64'(0));
        chk("mid_rst_rd_en", 64'(ifa.o_rd_en), 64'(0));
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("post_rst_done",  64'(ifa.o_done),  64'(0));
            chk("post_rst_wr_en", 64'(ifa.o_wr_en), 64'(0));
        end
        run_a(100, 0, 1'b0);

        // start pulses while busy and during DONE are ignored
        run_a(100, 0, 1'b1);

        // start together with reset stays idle
        ifa.i_start = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifa.i_start = 1'b0;
        chk("start_rst_busy", 64'(ifa.o_busy), 64'(0));
        tick();
        chk("start_rst_busy2", 64'(ifa.o_busy),  64'(0));
        chk("start_rst_rd_en", 64'(ifa.o_rd_en), 64'(0));

        // three iterations on dut_b
        writes = 0;
        dones  = 0;
        ifb.i_start = 1'b1;
        tick();
        ifb.i_start = 1'b0;
        for (int cyc = 0; cyc < 18; cyc++) begin
            chk("b_rd_en", 64'(ifb.o_rd_en), 64'(cyc < 12));
            if (cyc < 12) begin
                chk("b_rd_addr", 64'(ifb.o_rd_addr), 64'(cyc % 4));
                chk("b_iter",    64'(ifb.o_iter),    64'(cyc / 4));
            end
            chk("b_wr_en", 64'(ifb.o_wr_en), 64'(cyc >= 2 && cyc < 14));
            if (ifb.o_wr_en) begin
                writes++;
                chk("b_wr_addr", 64'(ifb.o_wr_addr), 64'((cyc - 2) % 4));
                chk("b_app",     64'(ifb.o_app),     64'(app_tab[(cyc - 2) % 4]));
            end
            chk("b_done", 64'(ifb.o_done), 64'(cyc == 14));
            if (ifb.o_done) dones++;
            tick();
        end
        chk("b_writes", 64'(writes), 64'(12));
        chk("b_dones",  64'(dones),  64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
